line_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache between the pipelined datapath and a line-wide memory port.
- The cpu top instantiates two of them: instruction side and data side.
- Datapath side uses a word request/ready handshake (16-bit); memory side moves 64-bit lines on read misses and single words on writes.
- Also keeps saturating hit and miss counters for performance reporting.

---
 rtl/line_cache_pkg.sv | 26 ++
 rtl/line_cache_array.sv | 43 ++++
 rtl/line_cache.sv | 151 +++++++++++++++
 tb/tb_line_cache.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_cache_pkg.sv
// Shared constants for line_cache: word/line geometry, address field positions,
// FSM state encoding and a saturating counter helper.
package line_cache_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned LINE_SIZE = 64;
    localparam int unsigned NUM_LINES = 4;

    localparam int unsigned OFF_W   = 2;
    localparam int unsigned IDX_LSB = 2;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned TAG_LSB = 4;
    localparam int unsigned TAG_W   = 12;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StResp  = 2'd1,
        StFill  = 2'd2,
        StWrMem = 2'd3
    } state_e;

    function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v);
        return (v == {WORD_SIZE{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/line_cache_array.sv
// Direct-mapped valid/tag/data storage: combinational lookup, synchronous
// whole-line fill and single-word write. Only the valid bits are reset.
module line_cache_array
    import line_cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     i_idx,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic [OFF_W-1:0]     i_off,
    output logic                 o_hit,
    output logic [WORD_SIZE-1:0] o_word,
    input  logic                 i_fill_en,
    input  logic [LINE_SIZE-1:0] i_fill_line,
    input  logic                 i_wr_en,
    input  logic [WORD_SIZE-1:0] i_wr_word
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_SIZE-1:0] r_data [NUM_LINES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_fill_line;
        end else if (i_wr_en) begin
            r_data[i_idx][{i_off, 4'b0000} +: WORD_SIZE] <= i_wr_word;
        end
    end

    assign o_hit  = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
    assign o_word = r_data[i_idx][{i_off, 4'b0000} +: WORD_SIZE];

endmodule

// File: rtl/line_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with a line-wide read
// port to memory, single-word write-through, and saturating hit/miss counters.
module line_cache
    import line_cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 readC,
    input  logic                 writeC,
    input  logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] wdata_dp,
    output logic [WORD_SIZE-1:0] rdata_dp,
    output logic                 readyC,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] mem_address,
    input  logic [LINE_SIZE-1:0] mem_rdata,
    output logic [LINE_SIZE-1:0] mem_wdata,
    input  logic                 readyM,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
);

    state_e                r_state, w_state_d;
    logic                  r_ready, w_ready_d;
    logic                  r_readm, w_readm_d;
    logic                  r_writem, w_writem_d;
    logic [WORD_SIZE-1:0]  r_rdata, w_rdata_d;
    logic [WORD_SIZE-1:0]  r_maddr, w_maddr_d;
    logic [LINE_SIZE-1:0]  r_mwdata, w_mwdata_d;
    logic [WORD_SIZE-1:0]  r_hits, w_hits_d;
    logic [WORD_SIZE-1:0]  r_misses, w_misses_d;

    logic                  w_hit;
    logic [WORD_SIZE-1:0]  w_word;
    logic                  w_fill_en;
    logic                  w_wr_en;
    logic [OFF_W-1:0]      w_off;
    logic [WORD_SIZE-1:0]  w_fill_word;

    assign w_off       = address[OFF_W-1:0];
    assign w_fill_word = mem_rdata[{w_off, 4'b0000} +: WORD_SIZE];

    line_cache_array u_array (
        .clk         (clk),
        .reset       (reset),
        .i_idx       (address[IDX_LSB +: IDX_W]),
        .i_tag       (address[TAG_LSB +: TAG_W]),
        .i_off       (w_off),
        .o_hit       (w_hit),
        .o_word      (w_word),
        .i_fill_en   (w_fill_en),
        .i_fill_line (mem_rdata),
        .i_wr_en     (w_wr_en),
        .i_wr_word   (wdata_dp)
    );

    always_comb begin
        w_state_d  = r_state;
        w_ready_d  = 1'b0;
        w_readm_d  = r_readm;
        w_writem_d = r_writem;
        w_rdata_d  = r_rdata;
        w_maddr_d  = r_maddr;
        w_mwdata_d = r_mwdata;
        w_hits_d   = r_hits;
        w_misses_d = r_misses;
        w_fill_en  = 1'b0;
        w_wr_en    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (writeC) begin
                    // Write-through always; only a hit touches the cached line.
                    w_wr_en    = w_hit;
                    w_writem_d = 1'b1;
                    w_maddr_d  = address;
                    w_mwdata_d = {{(LINE_SIZE - WORD_SIZE){1'b0}}, wdata_dp};
                    if (w_hit) w_hits_d = sat_inc(r_hits);
                    else       w_misses_d = sat_inc(r_misses);
                    w_state_d  = StWrMem;
                end else if (readC) begin
                    if (w_hit) begin
                        w_rdata_d = w_word;
                        w_hits_d  = sat_inc(r_hits);
                        w_ready_d = 1'b1;
                        w_state_d = StResp;
                    end else begin
                        w_misses_d = sat_inc(r_misses);
                        w_readm_d  = 1'b1;
                        w_maddr_d  = {address[WORD_SIZE-1:IDX_LSB], {IDX_LSB{1'b0}}};
                        w_state_d  = StFill;
                    end
                end
            end
            StFill: begin
                if (readyM) begin
                    w_fill_en = 1'b1;
                    w_rdata_d = w_fill_word;
                    w_readm_d = 1'b0;
                    w_ready_d = 1'b1;
                    w_state_d = StResp;
                end
            end
            StWrMem: begin
                if (readyM) begin
                    w_writem_d = 1'b0;
                    w_ready_d  = 1'b1;
                    w_state_d  = StResp;
                end
            end
            StResp: begin
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_ready  <= 1'b0;
            r_readm  <= 1'b0;
            r_writem <= 1'b0;
            r_rdata  <= '0;
            r_maddr  <= '0;
            r_mwdata <= '0;
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            r_state  <= w_state_d;
            r_ready  <= w_ready_d;
            r_readm  <= w_readm_d;
            r_writem <= w_writem_d;
            r_rdata  <= w_rdata_d;
            r_maddr  <= w_maddr_d;
            r_mwdata <= w_mwdata_d;
            r_hits   <= w_hits_d;
            r_misses <= w_misses_d;
        end
    end

    assign readyC      = r_ready;
    assign readM       = r_readm;
    assign writeM      = r_writem;
    assign rdata_dp    = r_rdata;
    assign mem_address = r_maddr;
    assign mem_wdata   = r_mwdata;
    assign hit_count   = r_hits;
    assign miss_count  = r_misses;

endmodule

// File: tb/tb_line_cache.sv
// Directed bench for line_cache: a word-level cache/memory model predicts hit or
// miss, memory traffic, read data, latency and counters for every request.
module tb_line_cache;

    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        readC, writeC;
    logic [15:0] address, wdata_dp, rdata_dp;
    logic        readyC, readM, writeM, readyM;
    logic [15:0] mem_address;
    logic [63:0] mem_rdata, mem_wdata;
    logic [15:0] hit_count, miss_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model: backing memory (sparse) and the cache contents as whole words.
    logic [15:0] mem_m [int];
    bit          m_valid [4];
    logic [11:0] m_tag   [4];
    logic [15:0] m_word  [4][4];
    int          m_hits, m_misses;

    line_cache dut (
        .clk         (clk),
        .reset       (reset),
        .readC       (readC),
        .writeC      (writeC),
        .address     (address),
        .wdata_dp    (wdata_dp),
        .rdata_dp    (rdata_dp),
        .readyC      (readyC),
        .readM       (readM),
        .writeM      (writeM),
        .mem_address (mem_address),
        .mem_rdata   (mem_rdata),
        .mem_wdata   (mem_wdata),
        .readyM      (readyM),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem_m.exists(int'(a))) return mem_m[int'(a)];
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Called at a negedge; presents one request, plays memory, checks every cycle.
    task automatic do_req(input bit wr, input bit both, input logic [15:0] a,
                          input logic [15:0] wd);
        int          idx, off, lat, mem_cnt;
        logic [11:0] tag;
        bit          hit, need_mem, got;
        logic [15:0] exp_addr, exp_rd, base;
        logic [63:0] line;
        idx      = int'(a[3:2]);
        off      = int'(a[1:0]);
        tag      = a[15:4];
        hit      = m_valid[idx] && (m_tag[idx] == tag);
        need_mem = wr || !hit;
        base     = {a[15:2], 2'b00};
        exp_addr = wr ? a : base;
        line     = {mem_rd(base + 16'd3), mem_rd(base + 16'd2), mem_rd(base + 16'd1),
                    mem_rd(base)};
        exp_rd   = hit ? m_word[idx][off] : mem_rd(a);
        if (hit) begin
            if (m_hits < 65535) m_hits++;
        end else begin
            if (m_misses < 65535) m_misses++;
        end
        if (wr) begin
            mem_m[int'(a)] = wd;
            if (hit) m_word[idx][off] = wd;
        end else if (!hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            for (int k = 0; k < 4; k++) m_word[idx][k] = line[16*k +: 16];
        end
        lat      = need_mem ? MEM_LAT : 0;
        mem_cnt  = 0;
        got      = 1'b0;
        address  = a;
        wdata_dp = wd;
        writeC   = wr;
        readC    = !wr || both;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            chk("rd_wr_exclusive", {63'd0, readM & writeM}, 64'd0);
            if (readyC) begin
                got    = 1'b1;
                readyM = 1'b0;
                readC  = 1'b0;
                writeC = 1'b0;
                chk("latency", c, lat);
                chk("mem_idle_at_ready", {readM, writeM}, 0);
                if (!wr) chk("rdata_dp", rdata_dp, exp_rd);
                chk("hit_count", hit_count, m_hits);
                chk("miss_count", miss_count, m_misses);
            end else begin
                readyM = 1'b0;
                if (need_mem) begin
                    chk("readM", readM, !wr);
                    chk("writeM", writeM, wr);
                    chk("mem_address", mem_address, exp_addr);
                    if (wr) chk("mem_wdata", mem_wdata, {48'd0, wd});
                    mem_cnt++;
                    if (mem_cnt == MEM_LAT) begin
                        readyM    = 1'b1;
                        mem_rdata = wr ? 64'hDEAD_BEEF_DEAD_BEEF : line;
                    end
                end else begin
                    chk("no_mem_on_hit", {readM, writeM}, 0);
                end
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL readyC_timeout: got no readyC expected readyC for addr %h", a);
            readC  = 1'b0;
            writeC = 1'b0;
            readyM = 1'b0;
        end
        @(negedge clk);
        chk("readyC_one_cycle", readyC, 0);
    endtask

    initial begin
        reset     = 1'b1;
        readC     = 1'b0;
        writeC    = 1'b0;
        address   = '0;
        wdata_dp  = '0;
        readyM    = 1'b0;
        mem_rdata = '0;
        mem_m[16'h0010] = 16'h1111;
        mem_m[16'h0011] = 16'h2222;
        mem_m[16'h0012] = 16'h3333;
        mem_m[16'h0013] = 16'h4444;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_readyC", readyC, 0);
        chk("rst_readM", readM, 0);
        chk("rst_writeM", writeM, 0);
        chk("rst_rdata", rdata_dp, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, then a hit in the same line.
        do_req(1'b0, 1'b0, 16'h0012, 16'h0000);
        chk("pin_cold_rdata", rdata_dp, 16'h3333);
        chk("pin_cold_miss", miss_count, 16'd1);
        do_req(1'b0, 1'b0, 16'h0013, 16'h0000);
        chk("pin_hit_rdata", rdata_dp, 16'h4444);
        chk("pin_hit_count", hit_count, 16'd1);

        // Write hit updates the line; write miss does not allocate.
        do_req(1'b1, 1'b0, 16'h0011, 16'hBEEF);
        do_req(1'b0, 1'b0, 16'h0011, 16'h0000);
        chk("pin_write_hit_rdata", rdata_dp, 16'hBEEF);
        do_req(1'b1, 1'b0, 16'h0050, 16'h1234);
        do_req(1'b0, 1'b0, 16'h0050, 16'h0000);
        chk("pin_no_alloc_rdata", rdata_dp, 16'h1234);
        chk("pin_hits_3", hit_count, 16'd3);
        chk("pin_misses_3", miss_count, 16'd3);

        // Conflict on index 0 between tags 0x001 and 0x011.
        do_req(1'b0, 1'b0, 16'h0012, 16'h0000);
        do_req(1'b0, 1'b0, 16'h0112, 16'h0000);
        do_req(1'b0, 1'b0, 16'h0012, 16'h0000);
        chk("pin_conflict_misses", miss_count, 16'd6);

        // readC and writeC together: the write wins.
        do_req(1'b1, 1'b1, 16'h0013, 16'h7777);
        do_req(1'b0, 1'b0, 16'h0013, 16'h0000);
        chk("pin_write_wins", rdata_dp, 16'h7777);

        // Reset in the middle of a fill abandons it.
        address = 16'h0112;
        readC   = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("fill_readM", readM, 1);
        end
        reset = 1'b1;
        #1;
        chk("midfill_readM", readM, 0);
        chk("midfill_readyC", readyC, 0);
        chk("midfill_hits", hit_count, 0);
        chk("midfill_misses", miss_count, 0);
        readC = 1'b0;
        model_reset();
        @(negedge clk);
        reset     = 1'b0;
        readyM    = 1'b1;
        mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk);
        readyM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("late_readyM_ignored", {readyC, readM, writeM}, 0);
            @(negedge clk);
        end
        do_req(1'b0, 1'b0, 16'h0012, 16'h0000);
        chk("pin_post_reset_miss", miss_count, 16'd1);
        chk("pin_post_reset_hits", hit_count, 16'd0);
        chk("pin_post_reset_rdata", rdata_dp, 16'h3333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
